// File: rtl/sensor_filter_pkg.sv
// Shared constants for the sensor front-end: default filter depths,
// IR bit positions and the line-lost state encoding.
package sensor_filter_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LOST_CYCLES_DEF     = 16;
  localparam int DARK_CNT_W          = 16;

  localparam int IR_LEFT   = 2;
  localparam int IR_CENTRE = 1;
  localparam int IR_RIGHT  = 0;

  typedef enum logic {
    ST_TRACKING = 1'b0,
    ST_LOST     = 1'b1
  } line_state_e;

endpackage

// File: rtl/sensor_filter_debounce_channel.sv
// One sensor channel: 2-flop synchronizer, then a disagreement counter that
// flips the stable value after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_channel
  import sensor_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // The edge that would make the count hit DEBOUNCE_CYCLES flips instead.
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sensor_filter.sv
// Debounced obstacle/IR sensor front-end with change strobe and line-lost detect.
//   state       | meaning
//   ST_TRACKING | line seen recently; dark cycles counted toward LOST_CYCLES
//   ST_LOST     | LOST_CYCLES consecutive dark cycles; line_lost asserted
module sensor_filter
  import sensor_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOST_CYCLES     = LOST_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_raw,
  input  logic [2:0] i_raw,
  output logic       S,
  output logic       I_2,
  output logic       I_1,
  output logic       I_0,
  output logic       change,
  output logic       line_lost
);

  localparam logic [DARK_CNT_W-1:0] LOST_MAX = DARK_CNT_W'(LOST_CYCLES);

  logic [3:0]            filt, filt_prev_q;
  logic                  change_q;
  logic [2:0]            ir_filt;
  line_state_e           state_q, state_d;
  logic [DARK_CNT_W-1:0] dark_cnt_q, dark_cnt_d, dark_inc;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s (
    .clk(clk), .reset(reset), .raw_i(s_raw), .stable_o(S)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_i2 (
    .clk(clk), .reset(reset), .raw_i(i_raw[IR_LEFT]), .stable_o(I_2)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_i1 (
    .clk(clk), .reset(reset), .raw_i(i_raw[IR_CENTRE]), .stable_o(I_1)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_i0 (
    .clk(clk), .reset(reset), .raw_i(i_raw[IR_RIGHT]), .stable_o(I_0)
  );

  assign filt    = {S, I_2, I_1, I_0};
  assign ir_filt = {I_2, I_1, I_0};

  always_comb begin
    state_d    = state_q;
    dark_cnt_d = dark_cnt_q;
    dark_inc   = (dark_cnt_q == LOST_MAX) ? dark_cnt_q : dark_cnt_q + DARK_CNT_W'(1);
    case (state_q)
      ST_TRACKING: begin
        if (ir_filt == 3'b000) begin
          dark_cnt_d = dark_inc;
          if (dark_inc == LOST_MAX) state_d = ST_LOST;
        end else begin
          dark_cnt_d = '0;
        end
      end
      ST_LOST: begin
        if (ir_filt != 3'b000) begin
          state_d    = ST_TRACKING;
          dark_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_TRACKING;
        dark_cnt_d = '0;
      end
    endcase
  end

  // change compares against last cycle's filtered value, so it lands one edge after the flip.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_prev_q <= '0;
      change_q    <= 1'b0;
      state_q     <= ST_TRACKING;
      dark_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt;
      change_q    <= |(filt ^ filt_prev_q);
      state_q     <= state_d;
      dark_cnt_q  <= dark_cnt_d;
    end
  end

  assign change    = change_q;
  assign line_lost = (state_q == ST_LOST);

endmodule

// File: tb/tb_sensor_filter.sv
// Directed bench for sensor_filter at DEBOUNCE_CYCLES=4, LOST_CYCLES=16.
module tb_sensor_filter;

  logic       clk;
  logic       reset;
  logic       s_raw;
  logic [2:0] i_raw;
  logic       S, I_2, I_1, I_0, change, line_lost;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  sensor_filter #(.DEBOUNCE_CYCLES(4), .LOST_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .s_raw(s_raw), .i_raw(i_raw),
    .S(S), .I_2(I_2), .I_1(I_1), .I_0(I_0),
    .change(change), .line_lost(line_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    s_raw = 1'b1;
    i_raw = 3'b111;
    #2 reset = 1'b0;
    #1;
    check("rst_outputs", {12'd0, S, I_2, I_1, I_0}, 16'h0);
    check("rst_change", {15'd0, change}, 16'h0);
    check("rst_line_lost", {15'd0, line_lost}, 16'h0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("rel_edge5", {12'd0, S, I_2, I_1, I_0}, 16'h0);
    tick(1);
    check("rel_edge6", {12'd0, S, I_2, I_1, I_0}, 16'hF);
    check("rel_edge6_change", {15'd0, change}, 16'h0);
    tick(1);
    check("rel_edge7_change", {15'd0, change}, 16'h1);
    tick(1);
    check("rel_edge8_change", {15'd0, change}, 16'h0);

    // All four fall together
    s_raw = 1'b0;
    i_raw = 3'b000;
    tick(6);
    check("fall_edge6", {12'd0, S, I_2, I_1, I_0}, 16'h0);
    check("fall_edge6_change", {15'd0, change}, 16'h0);
    tick(1);
    check("fall_edge7_change", {15'd0, change}, 16'h1);
    tick(1);
    check("fall_edge8_change", {15'd0, change}, 16'h0);

    // Three-cycle glitch on centre IR must be swallowed
    i_raw = 3'b010;
    tick(3);
    i_raw = 3'b000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("glitch_I1", {15'd0, I_1}, 16'h0);
      check("glitch_change", {15'd0, change}, 16'h0);
    end

    // Simultaneous rise of left and right
    i_raw = 3'b101;
    tick(5);
    check("simul_edge5", {13'd0, I_2, I_1, I_0}, 16'h0);
    tick(1);
    check("simul_edge6", {13'd0, I_2, I_1, I_0}, 16'h5);
    check("simul_edge6_change", {15'd0, change}, 16'h0);
    tick(1);
    check("simul_edge7_change", {15'd0, change}, 16'h1);
    tick(1);
    check("simul_edge8_change", {15'd0, change}, 16'h0);

    // Obstacle latency
    s_raw = 1'b1;
    tick(5);
    check("lat_edge5_S", {15'd0, S}, 16'h0);
    tick(1);
    check("lat_edge6_S", {15'd0, S}, 16'h1);
    check("lat_edge6_change", {15'd0, change}, 16'h0);
    tick(1);
    check("lat_edge7_change", {15'd0, change}, 16'h1);
    tick(1);
    check("lat_edge8_change", {15'd0, change}, 16'h0);

    // Line lost from a clean reset with dark IR
    reset = 1'b0;
    s_raw = 1'b0;
    i_raw = 3'b000;
    #1;
    check("ll_rst_outputs", {12'd0, S, I_2, I_1, I_0}, 16'h0);
    check("ll_rst_line_lost", {15'd0, line_lost}, 16'h0);
    tick(1);
    reset = 1'b1;
    tick(15);
    check("ll_edge15", {15'd0, line_lost}, 16'h0);
    check("ll_edge15_cnt", dut.dark_cnt_q, 16'd15);
    tick(1);
    check("ll_edge16", {15'd0, line_lost}, 16'h1);
    check("ll_edge16_cnt", dut.dark_cnt_q, 16'd16);
    tick(3);
    check("ll_sat", {15'd0, line_lost}, 16'h1);
    check("ll_sat_cnt", dut.dark_cnt_q, 16'd16);
    i_raw = 3'b010;
    tick(6);
    check("ll_I1_rise", {15'd0, I_1}, 16'h1);
    tick(1);
    check("ll_recover", {15'd0, line_lost}, 16'h0);
    check("ll_recover_cnt", dut.dark_cnt_q, 16'd0);

    // Reset mid-debounce: partial count on S discarded
    s_raw = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check("mid_rst_S", {15'd0, S}, 16'h0);
    check("mid_rst_I1", {15'd0, I_1}, 16'h0);
    check("mid_rst_change", {15'd0, change}, 16'h0);
    tick(1);
    reset = 1'b1;
    tick(5);
    check("mid_edge5_S", {15'd0, S}, 16'h0);
    check("mid_edge5_I1", {15'd0, I_1}, 16'h0);
    tick(1);
    check("mid_edge6_S", {15'd0, S}, 16'h1);
    check("mid_edge6_I1", {15'd0, I_1}, 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
